// File: rtl/core_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : core_ctrl_fsm
// Description : Multi-cycle RV32I control sequencer FETCH/DECODE/EXEC/MEM/WB.
//               Define ILLEGAL_TRAP_EN to trap on illegal classes (else NOP).
// Revision    : 1.0 - initial release
// ============================================================================
module core_ctrl_fsm #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [10:0]      op_flags,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_wr,
    output logic             mdr_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             retire,
    output logic             halted,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_HALT   = 3'd5;
    localparam logic [2:0] c_TRAP   = 3'd6;

    localparam int c_JAL    = 2;
    localparam int c_JALR   = 3;
    localparam int c_BRANCH = 4;
    localparam int c_LOAD   = 5;
    localparam int c_STORE  = 6;
    localparam int c_FENCE  = 9;
    localparam int c_SYSTEM = 10;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [10:0]      r_class;
    logic             r_halted;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;
    logic             w_illegal;
    logic             w_ld;
    logic             w_st;
    logic             w_br;
    logic             w_fence;
    logic             w_sys;
    logic             w_jump;
    logic             w_frozen;

    // A legal class has exactly one flag set, so the per-class decodes below
    // are mutually exclusive once the illegal case is masked out.
    assign w_illegal = (r_class == 11'd0) || ((r_class & (r_class - 11'd1)) != 11'd0);
    assign w_ld      = !w_illegal && r_class[c_LOAD];
    assign w_st      = !w_illegal && r_class[c_STORE];
    assign w_br      = !w_illegal && r_class[c_BRANCH];
    assign w_fence   = !w_illegal && r_class[c_FENCE];
    assign w_sys     = !w_illegal && r_class[c_SYSTEM];
    assign w_jump    = !w_illegal && (r_class[c_JAL] || r_class[c_JALR]);
    assign w_frozen  = (r_state == c_HALT) || (r_state == c_TRAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_FETCH:  if (imem_ready) w_next = c_DECODE;
            c_DECODE: w_next = c_EXEC;
            c_EXEC: begin
                if (w_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = c_TRAP;
`else
                    w_next = c_FETCH;
`endif
                end else if (w_ld || w_st) begin
                    w_next = c_MEM;
                end else if (w_br || w_fence) begin
                    w_next = c_FETCH;
                end else if (w_sys) begin
                    w_next = c_HALT;
                end else begin
                    w_next = c_WB;
                end
            end
            c_MEM:    if (dmem_ready) w_next = w_ld ? c_WB : c_FETCH;
            c_WB:     w_next = c_FETCH;
            c_HALT:   w_next = c_HALT;
            c_TRAP:   w_next = c_TRAP;
            default:  w_next = c_FETCH;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_wr  = 1'b0;
        mdr_we   = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        retire   = 1'b0;
        if (!rst) begin
            case (r_state)
                c_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                c_EXEC: begin
                    if (w_illegal) begin
`ifndef ILLEGAL_TRAP_EN
                        pc_we  = 1'b1;
                        retire = 1'b1;
`endif
                    end else if (w_br) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken;
                        retire = 1'b1;
                    end else if (w_fence) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else if (w_sys) begin
                        retire = 1'b1;
                    end
                end
                c_MEM: begin
                    // Class is latched, so request and direction hold until ready.
                    dmem_req = 1'b1;
                    dmem_wr  = w_st;
                    if (dmem_ready) begin
                        mdr_we = w_ld;
                        pc_we  = w_st;
                        retire = w_st;
                    end
                end
                c_WB: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = w_jump;
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_class       <= 11'd0;
            r_halted      <= 1'b0;
            r_cycle_cnt   <= {CNT_W{1'b0}};
            r_instret_cnt <= {CNT_W{1'b0}};
        end else begin
            if (r_state == c_DECODE) r_class <= op_flags;
            if (w_next == c_HALT)    r_halted <= 1'b1;
            if (!w_frozen)           r_cycle_cnt <= r_cycle_cnt + c_CNT_ONE;
            if (retire)              r_instret_cnt <= r_instret_cnt + c_CNT_ONE;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_trap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap <= 1'b0;
        end else if (w_next == c_TRAP) begin
            r_trap <= 1'b1;
        end
    end

    assign trap = r_trap;
`else
    assign trap = 1'b0;
`endif

    assign halted      = r_halted;
    assign state       = r_state;
    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;

endmodule
`default_nettype wire
